// File: rtl/sprite_blitter.sv
// sprite_blitter: writer side of the VGA frame buffer.
// Turns queued sprite draw commands into per-pixel frame-buffer writes,
// fetching pixel colours from a synchronous sprite ROM (1-cycle read).
//
// Ports (all in the clk_33m domain, rst is asynchronous active-high):
//   rst_screen_33m      frame-swap pulse; while high the whole blitter stalls
//   cmd_valid/cmd_ready command push handshake: a command is taken on a clock
//                       edge where both are high; cmd_ready = FIFO not full
//   cmd_x/y/w/h/base    sprite placement, size and ROM address of pixel (0,0)
//   rom_addr/rom_data   sprite ROM read port, data one cycle after address
//   write_x/y/palette   pixel write; palette 0 means "no write"
//   busy                FIFO non-empty or FSM not idle
//   frame_overrun       busy was high at the most recent frame-swap rising edge
//
// Optional feature macro: SPRITE_FLIP_EN adds cmd_flip (horizontal mirror).
module sprite_blitter #(
    parameter int COOR_WIDTH     = 12,
    parameter int FRAME_WIDTH    = 1280,
    parameter int FRAME_HEIGHT   = 300,
    parameter int SIZE_WIDTH     = 8,
    parameter int ROM_ADDR_WIDTH = 16,
    parameter int QUEUE_DEPTH    = 8
) (
    input  logic                      clk_33m,
    input  logic                      rst,
    input  logic                      rst_screen_33m,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [COOR_WIDTH-1:0]     cmd_x,
    input  logic [COOR_WIDTH-1:0]     cmd_y,
    input  logic [SIZE_WIDTH-1:0]     cmd_w,
    input  logic [SIZE_WIDTH-1:0]     cmd_h,
    input  logic [ROM_ADDR_WIDTH-1:0] cmd_base,
`ifdef SPRITE_FLIP_EN
    input  logic                      cmd_flip,
`endif
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [2:0]                rom_data,
    output logic [COOR_WIDTH-1:0]     write_x,
    output logic [COOR_WIDTH-1:0]     write_y,
    output logic [2:0]                write_palette,
    output logic                      busy,
    output logic                      frame_overrun
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);
    localparam logic [SIZE_WIDTH-1:0] SIZE_ONE = SIZE_WIDTH'(1);
    localparam logic [COOR_WIDTH:0] FRAME_W_C = (COOR_WIDTH+1)'(FRAME_WIDTH);
    localparam logic [COOR_WIDTH:0] FRAME_H_C = (COOR_WIDTH+1)'(FRAME_HEIGHT);

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DRAIN} state_t;

    // ---------------- command FIFO ----------------
    logic [COOR_WIDTH-1:0]     fx_mem [QUEUE_DEPTH];
    logic [COOR_WIDTH-1:0]     fy_mem [QUEUE_DEPTH];
    logic [SIZE_WIDTH-1:0]     fw_mem [QUEUE_DEPTH];
    logic [SIZE_WIDTH-1:0]     fh_mem [QUEUE_DEPTH];
    logic [ROM_ADDR_WIDTH-1:0] fb_mem [QUEUE_DEPTH];
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic empty, full, push, pop, en;

    state_t state_q, state_d;

    assign en     = !rst_screen_33m;
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push   = cmd_valid && !full;
    assign pop    = (state_q == LOAD) && en;

    always_ff @(posedge clk_33m) begin
        if (push) begin
            fx_mem[wr_ptr_q[PTR_W-1:0]] <= cmd_x;
            fy_mem[wr_ptr_q[PTR_W-1:0]] <= cmd_y;
            fw_mem[wr_ptr_q[PTR_W-1:0]] <= cmd_w;
            fh_mem[wr_ptr_q[PTR_W-1:0]] <= cmd_h;
            fb_mem[wr_ptr_q[PTR_W-1:0]] <= cmd_base;
        end
    end

`ifdef SPRITE_FLIP_EN
    logic ff_mem [QUEUE_DEPTH];
    logic flip_q, flip_d;
    always_ff @(posedge clk_33m) begin
        if (push) ff_mem[wr_ptr_q[PTR_W-1:0]] <= cmd_flip;
    end
`endif

    // ---------------- working registers and pipeline ----------------
    logic [COOR_WIDTH-1:0]     x_q, x_d, y_q, y_d;
    logic [SIZE_WIDTH-1:0]     w_q, w_d, h_q, h_d, i_q, i_d, j_q, j_d;
    logic [ROM_ADDR_WIDTH-1:0] row_base_q, row_base_d, rom_addr_q, rom_addr_d;
    logic                      drain_q, drain_d;
    // stage 1 travels alongside rom_addr, stage 2 alongside rom_data
    logic                      s1_valid_q, s1_valid_d, s1_clip_q, s1_clip_d;
    logic [COOR_WIDTH-1:0]     s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic                      s2_valid_q, s2_valid_d, s2_clip_q, s2_clip_d;
    logic [COOR_WIDTH-1:0]     s2_x_q, s2_x_d, s2_y_q, s2_y_d;
    logic [COOR_WIDTH-1:0]     write_x_q, write_x_d, write_y_q, write_y_d;
    logic [2:0]                write_pal_q, write_pal_d;
    logic                      stall_prev_q, stall_prev_d;
    logic [2:0]                rom_hold_q, rom_hold_d;
    logic                      overrun_q, overrun_d;

    logic [COOR_WIDTH:0]       x_sum, y_sum;
    logic [SIZE_WIDTH-1:0]     col;
    logic [ROM_ADDR_WIDTH-1:0] issue_addr;
    logic [2:0]                rom_sel;
    logic                      stall_rise;

    assign x_sum = {1'b0, x_q} + {{(COOR_WIDTH+1-SIZE_WIDTH){1'b0}}, i_q};
    assign y_sum = {1'b0, y_q} + {{(COOR_WIDTH+1-SIZE_WIDTH){1'b0}}, j_q};
`ifdef SPRITE_FLIP_EN
    assign col = flip_q ? (w_q - SIZE_ONE - i_q) : i_q;
`else
    assign col = i_q;
`endif
    // row_base tracks base + j*w, so no multiplier is needed
    assign issue_addr = row_base_q + {{(ROM_ADDR_WIDTH-SIZE_WIDTH){1'b0}}, col};

    // During a stall the ROM keeps re-reading the held rom_addr, which is one
    // pixel ahead of stage 2. The data that belonged to stage 2 is captured
    // on the first stall cycle and used on the first cycle after release.
    assign stall_rise = rst_screen_33m && !stall_prev_q;
    assign rom_sel    = stall_prev_q ? rom_hold_q : rom_data;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        x_d          = x_q;
        y_d          = y_q;
        w_d          = w_q;
        h_d          = h_q;
        i_d          = i_q;
        j_d          = j_q;
        row_base_d   = row_base_q;
        rom_addr_d   = rom_addr_q;
        drain_d      = drain_q;
        s1_valid_d   = en ? 1'b0 : s1_valid_q;
        s1_clip_d    = s1_clip_q;
        s1_x_d       = s1_x_q;
        s1_y_d       = s1_y_q;
        s2_valid_d   = s2_valid_q;
        s2_clip_d    = s2_clip_q;
        s2_x_d       = s2_x_q;
        s2_y_d       = s2_y_q;
        write_x_d    = write_x_q;
        write_y_d    = write_y_q;
        write_pal_d  = write_pal_q;
        stall_prev_d = rst_screen_33m;
        rom_hold_d   = stall_rise ? rom_data : rom_hold_q;
        overrun_d    = stall_rise ? busy : overrun_q;
`ifdef SPRITE_FLIP_EN
        flip_d       = flip_q;
`endif

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

        case (state_q)
            IDLE: if (!empty && en) state_d = LOAD;
            LOAD: if (en) begin
                x_d        = fx_mem[rd_ptr_q[PTR_W-1:0]];
                y_d        = fy_mem[rd_ptr_q[PTR_W-1:0]];
                w_d        = fw_mem[rd_ptr_q[PTR_W-1:0]];
                h_d        = fh_mem[rd_ptr_q[PTR_W-1:0]];
                row_base_d = fb_mem[rd_ptr_q[PTR_W-1:0]];
`ifdef SPRITE_FLIP_EN
                flip_d     = ff_mem[rd_ptr_q[PTR_W-1:0]];
`endif
                i_d        = '0;
                j_d        = '0;
                drain_d    = 1'b0;
                // empty sprites are dropped without issuing any pixel
                if (w_d == '0 || h_d == '0) state_d = IDLE;
                else                        state_d = DRAW;
            end
            DRAW: if (en) begin
                rom_addr_d = issue_addr;
                s1_valid_d = 1'b1;
                s1_x_d     = x_sum[COOR_WIDTH-1:0];
                s1_y_d     = y_sum[COOR_WIDTH-1:0];
                s1_clip_d  = (x_sum >= FRAME_W_C) || (y_sum >= FRAME_H_C);
                if (i_q == w_q - SIZE_ONE) begin
                    i_d = '0;
                    if (j_q == h_q - SIZE_ONE) begin
                        state_d = DRAIN;
                    end else begin
                        j_d        = j_q + SIZE_ONE;
                        row_base_d = row_base_q + {{(ROM_ADDR_WIDTH-SIZE_WIDTH){1'b0}}, w_q};
                    end
                end else begin
                    i_d = i_q + SIZE_ONE;
                end
            end
            DRAIN: if (en) begin
                drain_d = !drain_q;
                if (drain_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (en) begin
            s2_valid_d = s1_valid_q;
            s2_clip_d  = s1_clip_q;
            s2_x_d     = s1_x_q;
            s2_y_d     = s1_y_q;
            write_pal_d = 3'd0;
            if (s2_valid_q) begin
                write_x_d   = s2_x_q;
                write_y_d   = s2_y_q;
                write_pal_d = s2_clip_q ? 3'd0 : rom_sel;
            end
        end
    end

    always_ff @(posedge clk_33m or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            x_q          <= '0;
            y_q          <= '0;
            w_q          <= '0;
            h_q          <= '0;
            i_q          <= '0;
            j_q          <= '0;
            row_base_q   <= '0;
            rom_addr_q   <= '0;
            drain_q      <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_clip_q    <= 1'b0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            s2_valid_q   <= 1'b0;
            s2_clip_q    <= 1'b0;
            s2_x_q       <= '0;
            s2_y_q       <= '0;
            write_x_q    <= '0;
            write_y_q    <= '0;
            write_pal_q  <= 3'd0;
            stall_prev_q <= 1'b0;
            rom_hold_q   <= 3'd0;
            overrun_q    <= 1'b0;
`ifdef SPRITE_FLIP_EN
            flip_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            x_q          <= x_d;
            y_q          <= y_d;
            w_q          <= w_d;
            h_q          <= h_d;
            i_q          <= i_d;
            j_q          <= j_d;
            row_base_q   <= row_base_d;
            rom_addr_q   <= rom_addr_d;
            drain_q      <= drain_d;
            s1_valid_q   <= s1_valid_d;
            s1_clip_q    <= s1_clip_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            s2_valid_q   <= s2_valid_d;
            s2_clip_q    <= s2_clip_d;
            s2_x_q       <= s2_x_d;
            s2_y_q       <= s2_y_d;
            write_x_q    <= write_x_d;
            write_y_q    <= write_y_d;
            write_pal_q  <= write_pal_d;
            stall_prev_q <= stall_prev_d;
            rom_hold_q   <= rom_hold_d;
            overrun_q    <= overrun_d;
`ifdef SPRITE_FLIP_EN
            flip_q       <= flip_d;
`endif
        end
    end

    assign cmd_ready     = !full;
    assign rom_addr      = rom_addr_q;
    assign write_x       = write_x_q;
    assign write_y       = write_y_q;
    // the held pixel is suppressed during a stall and shown once on release
    assign write_palette = en ? write_pal_q : 3'd0;
    assign busy          = !empty || (state_q != IDLE);
    assign frame_overrun = overrun_q;
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: directed bench for sprite_blitter with an expected-write
// queue filled by the stimulus side and drained by a negedge monitor.
// Build with SPRITE_FLIP_EN defined to include the mirrored-sprite test.
module tb_sprite_blitter;
    logic        clk_33m = 1'b0;
    logic        rst = 1'b1;
    logic        rst_screen_33m = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [11:0] cmd_x = '0, cmd_y = '0;
    logic [7:0]  cmd_w = '0, cmd_h = '0;
    logic [15:0] cmd_base = '0;
    logic        cmd_flip = 1'b0;
    logic [15:0] rom_addr;
    logic [2:0]  rom_data = 3'd0;
    logic [11:0] write_x, write_y;
    logic [2:0]  write_palette;
    logic        busy, frame_overrun;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_write_cyc = 0;
    logic rom_mode = 1'b0;   // 0: data = addr&7, 1: data = 5
    // {must_follow_previous_write, x, y, palette}
    logic [27:0] exp_q[$];

    sprite_blitter dut (
        .clk_33m(clk_33m), .rst(rst), .rst_screen_33m(rst_screen_33m),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_base(cmd_base),
`ifdef SPRITE_FLIP_EN
        .cmd_flip(cmd_flip),
`endif
        .rom_addr(rom_addr), .rom_data(rom_data),
        .write_x(write_x), .write_y(write_y), .write_palette(write_palette),
        .busy(busy), .frame_overrun(frame_overrun)
    );

    // ---------------- clock / ROM model ----------------
    always #15 clk_33m = ~clk_33m;
    always @(posedge clk_33m) cyc <= cyc + 1;
    always @(posedge clk_33m) rom_data <= rom_mode ? 3'd5 : rom_addr[2:0];

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk_33m) begin
        if (!rst && write_palette != 3'd0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got x=%0d y=%0d pal=%0d exp=none",
                         write_x, write_y, write_palette);
            end else begin
                logic [27:0] e;
                e = exp_q.pop_front();
                if ({write_x, write_y, write_palette} !== e[26:0]) begin
                    failures++;
                    $display("FAIL pixel got x=%0d y=%0d pal=%0d exp x=%0d y=%0d pal=%0d",
                             write_x, write_y, write_palette, e[26:15], e[14:3], e[2:0]);
                end
                if (e[27]) begin
                    checks++;
                    if (cyc != last_write_cyc + 1) begin
                        failures++;
                        $display("FAIL pixel_gap got=%0d exp=%0d", cyc - last_write_cyc, 1);
                    end
                end
            end
            last_write_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Expected visible writes of one sprite, in raster order.
    task automatic expect_sprite(input int x, input int y, input int w, input int h,
                                 input int base, input bit flip, input bit consec);
        bit prev_vis = 0;
        for (int j = 0; j < h; j++) begin
            for (int i = 0; i < w; i++) begin
                int ax, ay, addr;
                logic [2:0] pal;
                logic [31:0] axv, ayv;
                ax = x + i;
                ay = y + j;
                addr = base + j * w + (flip ? (w - 1 - i) : i);
                pal = rom_mode ? 3'd5 : 3'(addr % 8);
                if (ax >= 1280 || ay >= 300) pal = 3'd0;
                axv = ax;
                ayv = ay;
                if (pal != 3'd0) exp_q.push_back({consec && prev_vis, axv[11:0], ayv[11:0], pal});
                prev_vis = (pal != 3'd0);
            end
        end
    endtask

    task automatic send_cmd(input int x, input int y, input int w, input int h,
                            input int base, input bit flip);
        int k;
        @(negedge clk_33m);
        cmd_x = 12'(x); cmd_y = 12'(y); cmd_w = 8'(w); cmd_h = 8'(h);
        cmd_base = 16'(base); cmd_flip = flip; cmd_valid = 1'b1;
        for (k = 0; k < 100 && !cmd_ready; k++) @(negedge clk_33m);
        if (k == 100) check("cmd_ready_timeout", 0, 1);
        @(negedge clk_33m);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_addr(input logic [15:0] a);
        int k;
        for (k = 0; k < 60; k++) begin
            @(negedge clk_33m);
            if (rom_addr == a) break;
        end
        if (k == 60) check("rom_addr_timeout", 32'(rom_addr), 32'(a));
    endtask

    task automatic wait_idle(input int limit);
        int k;
        for (k = 0; k < limit; k++) begin
            @(negedge clk_33m);
            if (!busy) break;
        end
        if (k == limit) check("idle_timeout", 32'(busy), 0);
        repeat (4) @(negedge clk_33m);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_acc;
        bit quiet;
        logic [15:0] held_addr;

        // reset values
        repeat (3) @(negedge clk_33m);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_write_x", 32'(write_x), 0);
        check("rst_write_y", 32'(write_y), 0);
        check("rst_palette", 32'(write_palette), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(frame_overrun), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk_33m);

        // basic 2x2 sprite, consecutive writes 2 cycles after first address
        rom_mode = 1'b0;
        expect_sprite(10, 20, 2, 2, 100, 0, 1);
        send_cmd(10, 20, 2, 2, 100, 0);
        wait_addr(16'd100);
        @(negedge clk_33m);
        check("addr_1", 32'(rom_addr), 101);
        @(negedge clk_33m);
        check("addr_2", 32'(rom_addr), 102);
        check("first_write", {5'd0, write_x, write_y, write_palette}, {5'd0, 12'd10, 12'd20, 3'd4});
        @(negedge clk_33m);
        check("addr_3", 32'(rom_addr), 103);
        wait_idle(100);
        check("basic_all_written", exp_q.size(), 0);

        // clipping at the right/bottom frame edge
        rom_mode = 1'b1;
        expect_sprite(1279, 299, 2, 2, 0, 0, 0);
        send_cmd(1279, 299, 2, 2, 0, 0);
        wait_idle(100);
        check("clip_all_written", exp_q.size(), 0);
        rom_mode = 1'b0;

        // stall for 16 cycles mid-sprite
        expect_sprite(100, 50, 7, 2, 1, 0, 0);
        send_cmd(100, 50, 7, 2, 1, 0);
        wait_addr(16'd4);
        rst_screen_33m = 1'b1;
        held_addr = rom_addr;
        quiet = 1;
        repeat (16) begin
            @(negedge clk_33m);
            if (write_palette != 3'd0) quiet = 0;
        end
        check("stall_quiet", 32'(quiet), 1);
        check("stall_addr_held", 32'(rom_addr), 32'(held_addr));
        check("overrun_set", 32'(frame_overrun), 1);
        rst_screen_33m = 1'b0;
        wait_idle(100);
        check("stall_all_written", exp_q.size(), 0);

        // fill the FIFO while stalled; empty sprites draw nothing
        rst_screen_33m = 1'b1;
        @(negedge clk_33m);
        check("overrun_cleared", 32'(frame_overrun), 0);
        n_acc = 0;
        for (int k = 0; k < 9; k++) begin
            int w, h;
            w = (k == 3) ? 0 : 1;
            h = (k == 5) ? 0 : 1;
            cmd_x = 12'(k * 3); cmd_y = 12'(5 + k); cmd_w = 8'(w); cmd_h = 8'(h);
            cmd_base = 16'((k % 7) + 1); cmd_flip = 1'b0; cmd_valid = 1'b1;
            if (k == 8) check("full_not_ready", 32'(cmd_ready), 0);
            if (cmd_ready) begin
                n_acc++;
                expect_sprite(k * 3, 5 + k, w, h, (k % 7) + 1, 0, 0);
            end
            @(negedge clk_33m);
        end
        cmd_valid = 1'b0;
        check("accepted_count", n_acc, 8);
        check("busy_while_stalled", 32'(busy), 1);
        rst_screen_33m = 1'b0;
        wait_idle(300);
        check("queue_all_written", exp_q.size(), 0);

`ifdef SPRITE_FLIP_EN
        // mirrored sprite: addresses descend, x ascends
        expect_sprite(40, 60, 3, 1, 0, 1, 1);
        send_cmd(40, 60, 3, 1, 0, 1);
        wait_addr(16'd2);
        @(negedge clk_33m);
        check("flip_addr_1", 32'(rom_addr), 1);
        @(negedge clk_33m);
        check("flip_addr_2", 32'(rom_addr), 0);
        wait_idle(100);
        check("flip_all_written", exp_q.size(), 0);
`endif

        // reset in the middle of drawing with 3 commands queued
        expect_sprite(0, 0, 20, 4, 0, 0, 0);
        send_cmd(0, 0, 20, 4, 0, 0);
        send_cmd(200, 10, 4, 4, 8, 0);
        send_cmd(300, 10, 4, 4, 16, 0);
        send_cmd(400, 10, 4, 4, 24, 0);
        @(negedge clk_33m);
        check("busy_before_reset", 32'(busy), 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_palette", 32'(write_palette), 0);
        check("mid_rst_write_x", 32'(write_x), 0);
        check("mid_rst_write_y", 32'(write_y), 0);
        check("mid_rst_rom_addr", 32'(rom_addr), 0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 1);
        check("mid_rst_busy", 32'(busy), 0);
        exp_q.delete();
        @(negedge clk_33m);
        rst = 1'b0;
        repeat (40) @(negedge clk_33m);
        check("fifo_emptied_busy", 32'(busy), 0);
        check("fifo_emptied_ready", 32'(cmd_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
